// File: rtl/arq_fifo_tx_if.sv
// Bus bundle for the ARQ transmitter: write port, transmit request and
// status/pulse outputs. The design drives the slave side.
interface arq_fifo_tx_if #(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 8,
  parameter int MAX_RETRY = 3
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ATT_W = $clog2(MAX_RETRY + 1);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [1:0]        err_mode;
  logic [DATA_W-1:0] data_out;
  logic              ack;
  logic              nack;
  logic              drop;
  logic              wr_overflow;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [ATT_W-1:0]  attempt;
  logic              busy;

  modport master (
    output wr_en, wr_data, rd_en, err_mode,
    input  data_out, ack, nack, drop, wr_overflow, full, empty, count, attempt, busy
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_mode,
    output data_out, ack, nack, drop, wr_overflow, full, empty, count, attempt, busy
  );
endinterface

// File: rtl/arq_fifo_tx.sv
// FIFO-backed stop-and-wait ARQ transmitter. Each attempt carries a parity
// check; a failed check retries the same head word until MAX_RETRY is spent.
module arq_fifo_tx #(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 8,
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 2
) (
  input  logic            clk,
  input  logic            rst,
  arq_fifo_tx_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ATT_W = $clog2(MAX_RETRY + 1);
  localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  typedef enum logic [1:0] {IDLE, SEND, CHECK, BACKOFF} state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ATT_W-1:0]   attempt_q;
  logic [GAP_W-1:0]   gap_q;
  logic [DATA_W-1:0]  tx_word_q, data_out_q;
  logic               tx_par_q;
  logic               ack_q, nack_q, drop_q, ovf_q;

  logic [DATA_W-1:0]  head;
  logic               full, empty, pass, last_try, pop, push;

  // Error injection: mode 11 leaves the final permitted attempt clean.
  function automatic logic corrupt(input logic [1:0] mode, input logic [ATT_W-1:0] att);
    case (mode)
      2'b00:   corrupt = 1'b0;
      2'b01:   corrupt = 1'b1;
      2'b10:   corrupt = (att == '0);
      default: corrupt = (att < ATT_W'(MAX_RETRY));
    endcase
  endfunction

  assign head     = mem_q[rptr_q];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign pass     = ((^tx_word_q) == tx_par_q);
  assign last_try = (attempt_q == ATT_W'(MAX_RETRY));
  assign pop      = (state_q == CHECK) && (pass || last_try);
  assign push     = bus.wr_en && (!full || pop);

  always_comb begin
    wptr_d  = wptr_q + PTR_W'(push);
    rptr_d  = rptr_q + PTR_W'(pop);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= bus.wr_en && full && !pop;
    end
  end

  // ---- SEND -> CHECK boundary: transmitted word and its reference parity
  always_ff @(posedge clk) begin
    if (state_q == SEND) begin
      tx_par_q  <= ^head;
      tx_word_q <= head ^ DATA_W'(corrupt(bus.err_mode, attempt_q));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      attempt_q  <= '0;
      gap_q      <= '0;
      data_out_q <= '0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      nack_q <= 1'b0;
      drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.rd_en && !empty) begin
            state_q   <= SEND;
            attempt_q <= '0;
          end
        end
        SEND: state_q <= CHECK;
        CHECK: begin
          if (pass) begin
            ack_q      <= 1'b1;
            data_out_q <= tx_word_q;
            state_q    <= IDLE;
          end else begin
            nack_q <= 1'b1;
            if (last_try) begin
              drop_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              attempt_q <= attempt_q + 1'b1;
              gap_q     <= '0;
              state_q   <= (RETRY_GAP == 0) ? SEND : BACKOFF;
            end
          end
        end
        BACKOFF: begin
          if (gap_q == GAP_W'(RETRY_GAP - 1)) state_q <= SEND;
          else                                gap_q   <= gap_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.ack         = ack_q;
  assign bus.nack        = nack_q;
  assign bus.drop        = drop_q;
  assign bus.wr_overflow = ovf_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.count       = count_q;
  assign bus.attempt     = attempt_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: doc/arq_fifo_tx.md
Name: arq_fifo_tx

Overview:
- Parametrised FIFO-backed stop-and-wait ARQ transmitter.
- Replaces the fixed 4-bit, fixed-policy tx FSM with configurable width, depth, retry limit and backoff gap.
- Adds a drop-after-max-retry policy, overflow flagging and an extra error-injection mode.
- Sits between the pin-level input wrapper and the link model. Each transmission carries an internal parity check that generates ack/nack.

Parameters:
- DATA_W, 4, payload width in bits (>=2).
- DEPTH, 8, FIFO entries; power of two, >=2.
- MAX_RETRY, 3, retransmissions allowed after the first attempt (>=1).
- RETRY_GAP, 2, idle cycles in BACKOFF between a nack and the next attempt (0 allowed).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  push wr_data.
- wr_data  in  DATA_W  word to enqueue.
- rd_en  in  1  request transmission of the FIFO head; sampled only in IDLE.
- err_mode  in  2  error-injection policy, sampled in SEND.
- data_out  out  DATA_W  last successfully delivered word; holds its value until the next ack.
- ack  out  1  one-cycle pulse, delivery succeeded.
- nack  out  1  one-cycle pulse, one attempt failed.
- drop  out  1  one-cycle pulse, head discarded after MAX_RETRY+1 failures.
- wr_overflow  out  1  one-cycle pulse, write rejected.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- count  out  $clog2(DEPTH)+1  occupancy.
- attempt  out  $clog2(MAX_RETRY+1)  index of the current attempt.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset, asynchronous:
  - FSM goes to IDLE; pointers, count and attempt go to 0.
  - empty=1; full, busy, ack, nack, drop, wr_overflow = 0; data_out=0.
  - Reset mid-transfer discards all FIFO contents and any retry state.
- FSM states:
  - IDLE: rd_en=1 && !empty -> SEND, attempt=0. rd_en while empty is ignored, with no pulse.
  - SEND (1 cycle): latch tx_par = XOR-reduce(head) and tx_word = head ^ {0..,corrupt}.
    - corrupt by err_mode: 00 never; 01 always; 10 only when attempt==0; 11 when attempt<MAX_RETRY (the final attempt is clean).
    - -> CHECK.
  - CHECK (1 cycle):
    - If XOR(tx_word)==tx_par: ack=1, data_out<=tx_word, pop head, -> IDLE.
    - Else nack=1. If attempt==MAX_RETRY: drop=1 in the same cycle, pop head, -> IDLE.
    - Else attempt++, -> BACKOFF, or straight to SEND if RETRY_GAP==0.
  - BACKOFF: counts RETRY_GAP cycles, then -> SEND. rd_en is ignored.
- Latency:
  - rd_en sampled at edge k -> SEND in cycle k+1 -> ack/nack visible after edge k+2.
  - Each retry adds RETRY_GAP+2 cycles.
- Outputs: ack, nack, drop, wr_overflow are registered and high for exactly one cycle.
- FIFO rules:
  - Head is not popped during retries; the same word is resent.
  - Pop happens only on ack or drop.
  - Write when !full: accepted.
  - Write when full and a pop in the same cycle: accepted, count unchanged.
  - Write when full with no pop: rejected, wr_overflow=1, contents unchanged.
  - Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
  - Writes are accepted in every FSM state.
- err_mode may change between attempts; each attempt uses the value sampled in its own SEND cycle.

Test Plan (DATA_W=4, DEPTH=8, MAX_RETRY=3, RETRY_GAP=2):
1. Reset; write 0,A,3,2 -> count=4. rd_en pulse, err_mode=00 -> ack 2 cycles later, data_out=0, count=3, nack never high.
2. err_mode=01, rd_en -> four nack pulses 4 cycles apart; drop with the 4th nack; no ack; data_out stays 0; count=2 (A discarded).
3. err_mode=10, rd_en -> one nack, then ack 4 cycles later; data_out=3, count=1, attempt=1 at ack.
4. err_mode=11, rd_en -> three nacks then ack on attempt 3; data_out=2; count=0, empty=1. A following rd_en is ignored, busy stays 0.
5. Write 8 words -> full=1. 9th write -> wr_overflow pulse, count=8. Then rd_en err=00 with a write in the ack cycle -> accepted, count=8, new word is last out.
6. Start err_mode=01 transfer, assert rst during BACKOFF -> all outputs at reset values immediately, empty=1, count=0, busy=0; rd_en afterwards is ignored.
